// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU bus bridge: length codes, FSM states,
// the bus request payload and the store lane helpers.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
  } bus_req_t;

  function automatic logic [3:0] strobe_gen(input logic [1:0] len, input logic [1:0] off);
    case (len)
      LEN_BYTE: return 4'(4'b0001 << off);
      LEN_HALF: return 4'(4'b0011 << off);
      LEN_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
    return ((len == LEN_HALF) && off[0]) || ((len == LEN_WORD) && (off != 2'b00));
  endfunction

  // Replicate the right-justified store value across all lanes it may land on.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] len, input logic [DATA_W-1:0] data);
    case (len)
      LEN_BYTE: return {4{data[7:0]}};
      LEN_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a returned bus word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [1:0]        length,
  input  logic              is_signed,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = 8'h00;
    half_c   = offset[1] ? rdata[31:16] : rdata[15:0];
    result_c = rdata;
    case (offset)
      2'd0:    byte_c = rdata[7:0];
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      default: byte_c = rdata[31:24];
    endcase
    case (length)
      LEN_BYTE: result_c = {{24{is_signed & byte_c[7]}}, byte_c};
      LEN_HALF: result_c = {{16{is_signed & half_c[15]}}, half_c};
      default:  result_c = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit bridging the datapath's memory requests onto a valid/ready bus.
// Optional WAIT-state timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  SYS_clk,
  input  logic                  SYS_reset,
  input  logic                  LSU_load_req,
  input  logic [1:0]            MEM_read_length,
  input  logic                  MEM_read_signed,
  input  logic [31:0]           MEM_read_address,
  input  logic [1:0]            MEM_write_length,
  input  logic [31:0]           MEM_write_address,
  input  logic [31:0]           MEM_write_data,
  output logic [31:0]           MEM_read_data,
  output logic                  LSU_stall,
  output logic                  LSU_fault,
  output logic [31:0]           LSU_fault_addr,
  output logic                  BUS_req_valid,
  input  logic                  BUS_req_ready,
  output logic                  BUS_req_write,
  output logic [ADDR_WIDTH-1:0] BUS_req_addr,
  output logic [31:0]           BUS_req_wdata,
  output logic [3:0]            BUS_req_wstrb,
  input  logic                  BUS_resp_valid,
  input  logic [31:0]           BUS_resp_rdata,
  input  logic                  BUS_resp_error
);

  if (ADDR_WIDTH < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("lsu_bus_bridge: ADDR_WIDTH must be >= 2 and TIMEOUT_CYCLES > 0");
  end

  state_e      state_q, state_d;
  bus_req_t    req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;
  logic [31:0] baddr_q, baddr_d;
  logic [1:0]  len_q, len_d;
  logic        sgn_q, sgn_d;
  logic        stall_c;
  logic [31:0] align_c;
  logic        tmo_hit_c;

  // A store and a load in the same instruction never happen; store wins if they do.
  logic        is_store_c, access_c, misalign_c;
  logic [1:0]  acc_len_c;
  logic [31:0] acc_addr_c;

  assign is_store_c = (MEM_write_length != LEN_NONE);
  assign access_c   = is_store_c | LSU_load_req;
  assign acc_len_c  = is_store_c ? MEM_write_length : MEM_read_length;
  assign acc_addr_c = is_store_c ? MEM_write_address : MEM_read_address;
  assign misalign_c = misaligned(acc_len_c, acc_addr_c[1:0]);

  lsu_load_align u_align (
    .rdata     (BUS_resp_rdata),
    .offset    (baddr_q[1:0]),
    .length    (len_q),
    .is_signed (sgn_q),
    .result_c  (align_c)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts completed WAIT cycles; zero whenever the FSM is outside WAIT.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) tmo_q <= '0;
    else if (state_q == ST_WAIT && state_d == ST_WAIT) tmo_q <= tmo_q + TMO_W'(1);
    else tmo_q <= '0;
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      faddr_q <= '0;
      baddr_q <= '0;
      len_q   <= LEN_NONE;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
      baddr_q <= baddr_d;
      len_q   <= len_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    faddr_d = faddr_q;
    baddr_d = baddr_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          stall_c = 1'b1;
          baddr_d = acc_addr_c;
          len_d   = acc_len_c;
          sgn_d   = MEM_read_signed;
          if (misalign_c) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
            faddr_d = acc_addr_c;
            if (!is_store_c) rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            valid_d     = 1'b1;
            req_d.write = is_store_c;
            req_d.addr  = {acc_addr_c[31:2], 2'b00};
            req_d.wdata = is_store_c ? store_lanes(acc_len_c, MEM_write_data) : '0;
            req_d.wstrb = is_store_c ? strobe_gen(acc_len_c, acc_addr_c[1:0]) : 4'b0000;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (BUS_req_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (BUS_resp_valid) begin
          state_d = ST_DONE;
          if (BUS_resp_error) begin
            fault_d = 1'b1;
            faddr_d = baddr_q;
          end
          if (!req_q.write) rdata_d = BUS_resp_error ? '0 : align_c;
        end else if (tmo_hit_c) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
          faddr_d = baddr_q;
          if (!req_q.write) rdata_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign LSU_stall      = SYS_reset & stall_c;
  assign MEM_read_data  = rdata_q;
  assign LSU_fault      = fault_q;
  assign LSU_fault_addr = faddr_q;
  assign BUS_req_valid  = valid_q;
  assign BUS_req_write  = req_q.write;
  assign BUS_req_addr   = ADDR_WIDTH'(req_q.addr);
  assign BUS_req_wdata  = req_q.wdata;
  assign BUS_req_wstrb  = req_q.wstrb;

endmodule
